// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the instruction-memory program loader:
// state encodings, the default word-address width and small decode helpers.
package riscv_pipe_pkg;

    // Default instruction-memory word-address width (depth 2^7 = 128 words).
    localparam int unsigned IMEM_ADDR_W_DEF = 7;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERR   = 3'd6
    } ldr_state_e;

    // States in which a stream byte may be accepted.
    function automatic logic fn_rx_ready(input ldr_state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

    // States that make up an in-progress load.
    function automatic logic fn_busy(input ldr_state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_WRITE) || (s == ST_CSUM);
    endfunction

    // One step of the running XOR checksum over the data bytes.
    function automatic logic [7:0] fn_csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory program loader. Receives a byte stream
// (count N, 4N little-endian data bytes, XOR checksum), writes the words
// into instruction memory and releases the CPU reset only after a load
// whose checksum matches. All outputs are registered.
module imem_loader
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rstn,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Count width: wide enough for the 8-bit count byte and for 2^ADDR_W.
    localparam int unsigned CW = ((ADDR_W + 1) > 9) ? (ADDR_W + 1) : 9;
    localparam logic [CW-1:0] C_DEPTH = CW'(1) << ADDR_W;

    // State and datapath registers
    ldr_state_e        r_state;
    logic [CW-1:0]     r_n;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_bcnt;
    logic [31:0]       r_word;
    logic [7:0]        r_xor;

    // Registered outputs
    logic              r_rx_ready;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;
    logic              r_cpu_rstn;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    // Next-state values
    ldr_state_e        w_state_nxt;
    logic [CW-1:0]     w_n_nxt;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [1:0]        w_bcnt_nxt;
    logic [31:0]       w_word_nxt;
    logic [7:0]        w_xor_nxt;

    logic              w_acc;
    logic              w_len_bad;
    logic [CW-1:0]     w_idx_p1;

    // A byte moves only when the registered ready and the source's valid coincide.
    assign w_acc     = rx_valid & r_rx_ready;
    assign w_len_bad = (rx_data == 8'd0) || (CW'(rx_data) > C_DEPTH);
    assign w_idx_p1  = CW'(r_idx) + CW'(1);

    // Next-state and datapath update logic for the loader FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_idx_nxt   = r_idx;
        w_bcnt_nxt  = r_bcnt;
        w_word_nxt  = r_word;
        w_xor_nxt   = r_xor;
        case (r_state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    w_state_nxt = ST_LEN;
                    w_idx_nxt   = {ADDR_W{1'b0}};
                    w_bcnt_nxt  = 2'd0;
                    w_xor_nxt   = 8'd0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_LEN: begin
                if (w_acc) begin
                    if (w_len_bad) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_n_nxt     = CW'(rx_data);
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_DATA: begin
                if (w_acc) begin
                    // Shifting in from the top leaves byte 0 in bits [7:0] after four bytes.
                    w_word_nxt = {rx_data, r_word[31:8]};
                    w_xor_nxt  = fn_csum_step(r_xor, rx_data);
                    if (r_bcnt == 2'd3) begin
                        w_bcnt_nxt  = 2'd0;
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_bcnt_nxt  = r_bcnt + 2'd1;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_WRITE: begin
                w_idx_nxt = r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (w_idx_p1 == r_n) begin
                    w_state_nxt = ST_CSUM;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (w_acc) begin
                    if (rx_data == r_xor) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end else begin
                    w_state_nxt = ST_CSUM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State/datapath registers and outputs decoded from the next state, so each
    // output is a flop that is valid for exactly the cycles spent in its state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_n        <= {CW{1'b0}};
            r_idx      <= {ADDR_W{1'b0}};
            r_bcnt     <= 2'd0;
            r_word     <= 32'd0;
            r_xor      <= 8'd0;
            r_rx_ready <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= {ADDR_W{1'b0}};
            r_im_wdata <= 32'd0;
            r_cpu_rstn <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_n        <= w_n_nxt;
            r_idx      <= w_idx_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_word     <= w_word_nxt;
            r_xor      <= w_xor_nxt;
            r_rx_ready <= fn_rx_ready(w_state_nxt);
            r_im_we    <= (w_state_nxt == ST_WRITE);
            r_im_addr  <= r_idx;
            r_im_wdata <= w_word_nxt;
            r_cpu_rstn <= (w_state_nxt == ST_RUN);
            r_busy     <= fn_busy(w_state_nxt);
            r_done     <= (w_state_nxt == ST_RUN);
            r_err      <= (w_state_nxt == ST_ERR);
        end
    end

    assign rx_ready = r_rx_ready;
    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign cpu_rstn = r_cpu_rstn;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued when a
// stream is built and popped when the loader strobes im_we.
module tb_imem_loader;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_rstn;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  stream[$];
    logic [31:0] words[$];
    logic [7:0]  good_s [11];
    wr_t         mon_e;
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic new_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    // Stream model: count, little-endian words, XOR checksum (optionally corrupted).
    task automatic build_load(input int n, input logic [7:0] csum_flip);
        logic [7:0]  x;
        logic [31:0] w;
        wr_t         e;
        x = 8'd0;
        stream.delete();
        stream.push_back(n[7:0]);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                stream.push_back(w[8*k +: 8]);
                x = x ^ w[8*k +: 8];
            end
            e.a = AW'(i);
            e.d = w;
            exp_q.push_back(e);
        end
        stream.push_back(x ^ csum_flip);
    endtask

    // Present one byte (after an optional random gap) and return on the
    // falling edge following the rising edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int g;
        int tmo;
        g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        repeat (g) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tmo = 0;
        while (rx_ready !== 1'b1 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 20) check_eq("rdy_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_stream(input int gapmax);
        for (int i = 0; i < stream.size(); i++) send_byte(stream[i], gapmax);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // {busy, done, err, cpu_rstn}
    task automatic check_status(input string tag, input logic [3:0] exp);
        check_eq(tag, {28'd0, busy, done, err, cpu_rstn}, {28'd0, exp});
    endtask

    // Scoreboard: every write strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (rstn && im_we) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_we", {25'd0, im_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("we_addr", {25'd0, im_addr}, {25'd0, mon_e.a});
                check_eq("we_data", im_wdata, mon_e.d);
            end
            check_eq("rdy_in_write", {31'd0, rx_ready}, 32'd0);
        end
    end

    initial begin
        good_s = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1, 8'h00};
        rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_outs", {26'd0, rx_ready, im_we, busy, done, err, cpu_rstn}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_status("idle", 4'b0000);

        // Known good program
        pulse_start();
        check_status("start_busy", 4'b1000);
        check_eq("start_rdy", {31'd0, rx_ready}, 32'd1);
        stream.delete();
        for (int i = 0; i < 10; i++) stream.push_back(good_s[i]);
        exp_q.push_back(wr_t'({7'd0, 32'h0050_0093}));
        exp_q.push_back(wr_t'({7'd1, 32'h0010_0113}));
        send_stream(0);
        check_status("good_run", 4'b0101);
        check_eq("good_sb", exp_q.size(), 32'd0);

        // Reload from RUN with a corrupted checksum
        pulse_start();
        check_status("reload", 4'b1000);
        stream[9] = 8'hC0;
        exp_q.push_back(wr_t'({7'd0, 32'h0050_0093}));
        exp_q.push_back(wr_t'({7'd1, 32'h0010_0113}));
        send_stream(0);
        check_status("badcs_err", 4'b0010);
        repeat (5) @(negedge clk);
        check_status("err_hold", 4'b0010);
        check_eq("err_rdy", {31'd0, rx_ready}, 32'd0);
        check_eq("badcs_sb", exp_q.size(), 32'd0);

        // Illegal counts: zero and one past the memory depth
        pulse_start();
        stream.delete(); stream.push_back(8'h00);
        send_stream(0);
        check_status("len00_err", 4'b0010);
        pulse_start();
        stream.delete(); stream.push_back(8'h81);
        send_stream(0);
        check_status("len81_err", 4'b0010);
        repeat (3) @(negedge clk);

        // Largest legal count, random gaps
        new_words(128);
        build_load(128, 8'h00);
        pulse_start();
        send_stream(2);
        check_status("n128_run", 4'b0101);
        check_eq("n128_sb", exp_q.size(), 32'd0);

        // Flow control: valid held across word boundaries, then the same data with gaps
        new_words(3);
        build_load(3, 8'h00);
        pulse_start();
        send_stream(0);
        check_status("held_run", 4'b0101);
        build_load(3, 8'h00);
        pulse_start();
        send_stream(3);
        check_status("gaps_run", 4'b0101);
        check_eq("flow_sb", exp_q.size(), 32'd0);

        // Reset in the middle of a load, then a clean load
        new_words(2);
        build_load(2, 8'h00);
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
        rx_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_eq("midrst_outs", {26'd0, rx_ready, im_we, busy, done, err, cpu_rstn}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_eq("midrst_hold", {26'd0, rx_ready, im_we, busy, done, err, cpu_rstn}, 32'd0);
        rstn = 1'b1;
        build_load(2, 8'h00);
        pulse_start();
        send_stream(1);
        check_status("after_rst_run", 4'b0101);
        check_eq("after_rst_sb", exp_q.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
